// File: rtl/spi_host.sv
// SPI-style frame initiator sharing the system clock: shifts a WIDTH-bit word out MSB-first under
// active-low select and captures the responder's miso stream with a fixed return latency.
module spi_host #(
  parameter int WIDTH    = 96,
  parameter int MISO_LAT = 1,
  parameter int GAP      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_tx_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_ss,
  output logic             o_mosi,
  input  logic             i_miso
);

  // state  | meaning
  // IDLE   | select high, waiting for i_start
  // SHIFT  | select low, one mosi bit per cycle for WIDTH cycles
  // DRAIN  | select high, collecting the last MISO_LAT returned bits
  // GAP    | select high, busy; result published in the first cycle

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_GAP} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [GW-1:0] GAP_LD   = GW'(GAP - 1);
  localparam logic [1:0]    DRAIN_LD = (MISO_LAT > 0) ? 2'(MISO_LAT - 1) : 2'd0;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-2:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [1:0]       drain_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             done_pend;
  logic             cap_now;

  // A capture slot is a select-low cycle seen MISO_LAT cycles later.
  if (MISO_LAT == 0) begin : g_cap0
    assign cap_now = ~o_ss;
  end else begin : g_capn
    logic [MISO_LAT-1:0] ss_hist;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ss_hist <= '0;
      end else begin
        ss_hist[0] <= ~o_ss;
        for (int i = 1; i < MISO_LAT; i++) ss_hist[i] <= ss_hist[i-1];
      end
    end
    assign cap_now = ss_hist[MISO_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      o_ss      <= 1'b1;
      o_mosi    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_rx_data <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      drain_cnt <= '0;
      gap_cnt   <= '0;
      done_pend <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (cap_now) rx_sr <= {rx_sr[WIDTH-2:0], i_miso};

      case (state)
        S_IDLE: begin
          if (i_start) begin
            tx_sr   <= i_tx_data[WIDTH-2:0];
            bit_cnt <= '0;
            o_ss    <= 1'b0;
            o_mosi  <= i_tx_data[WIDTH-1];
            o_busy  <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            o_ss   <= 1'b1;
            o_mosi <= 1'b0;
            if (MISO_LAT == 0) begin
              state     <= S_GAP;
              gap_cnt   <= GAP_LD;
              done_pend <= 1'b1;
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= DRAIN_LD;
            end
          end else begin
            o_mosi <= tx_sr[WIDTH-2];
            tx_sr  <= tx_sr << 1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'd0) begin
            state     <= S_GAP;
            gap_cnt   <= GAP_LD;
            done_pend <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_GAP: begin
          // The last bit landed in rx_sr on the edge that entered GAP.
          if (done_pend) begin
            o_done    <= 1'b1;
            o_rx_data <= rx_sr;
            done_pend <= 1'b0;
          end
          if (gap_cnt == '0) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host.sv
// Bench for spi_host: four instances with different WIDTH/MISO_LAT, loopback responders,
// and a scoreboard queue drained by a monitor on every o_done pulse.
module tb_spi_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_v   [4];
  logic        start_v [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic        ss_v    [4];
  logic        mosi_v  [4];
  logic        miso_v  [4];
  logic [95:0] tx_v    [4];
  logic [95:0] rx_v    [4];

  function automatic int w_of(input int i);
    return (i == 1 || i == 3) ? 16 : 96;
  endfunction

  // 0: W96 L1, 1: W16 L0, 2: W96 L3 (miso tied high), 3: W16 L1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 1 || g == 3) ? 16 : 96;
    localparam int L = (g == 1) ? 0 : ((g == 2) ? 3 : 1);
    logic [W-1:0] rx_w;
    spi_host #(.WIDTH(W), .MISO_LAT(L), .GAP(2)) u_dut (
      .clk      (clk),
      .rst_n    (rst_v[g]),
      .i_start  (start_v[g]),
      .i_tx_data(tx_v[g][W-1:0]),
      .o_busy   (busy_v[g]),
      .o_done   (done_v[g]),
      .o_rx_data(rx_w),
      .o_ss     (ss_v[g]),
      .o_mosi   (mosi_v[g]),
      .i_miso   (miso_v[g])
    );
    assign rx_v[g] = 96'(rx_w);
    if (g == 2) begin : g_one
      assign miso_v[g] = 1'b1;
    end else if (L == 0) begin : g_l0
      assign miso_v[g] = ss_v[g] ? 1'b0 : mosi_v[g];
    end else begin : g_l1
      logic d1 = 1'b0;
      always @(posedge clk) d1 <= ss_v[g] ? 1'b0 : mosi_v[g];
      assign miso_v[g] = d1;
    end
  end

  typedef struct {
    int          id;
    logic [95:0] data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pending(input int i);
    int n = 0;
    foreach (sb[j]) if (sb[j].id == i) n++;
    return n;
  endfunction

  logic ss_prev  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  int   run_low  [4] = '{0, 0, 0, 0};
  int   run_high [4] = '{0, 0, 0, 0};
  int   last_fall[4] = '{0, 0, 0, 0};
  int   falls    [4] = '{0, 0, 0, 0};
  bit   abort_v  [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    int k;
    for (int i = 0; i < 4; i++) begin
      if (done_v[i] === 1'b1) begin
        k = -1;
        for (int j = 0; j < sb.size(); j++) begin
          if (sb[j].id == i) begin
            k = j;
            break;
          end
        end
        if (k < 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done[%0d]: got o_done=1 expected no pulse", i);
        end else begin
          chk($sformatf("rx_data[%0d]", i), rx_v[i], sb[k].data);
          if (sb[k].lat >= 0)
            chk($sformatf("done_latency[%0d]", i), 96'(cyc - sb[k].acc), 96'(sb[k].lat));
          sb.delete(k);
        end
      end
      if (ss_v[i] === 1'b0) begin
        if (ss_prev[i]) begin
          if (i == 3 && falls[i] > 0) begin
            chk("accept_interval[3]", 96'(cyc - last_fall[i]), 96'd20);
            chk("ss_high_cycles[3]", 96'(run_high[i]), 96'd4);
          end
          falls[i]++;
          last_fall[i] = cyc;
          run_low[i]   = 0;
        end
        run_low[i]++;
      end else begin
        if (!ss_prev[i]) begin
          if (abort_v[i]) abort_v[i] = 1'b0;
          else chk($sformatf("ss_low_cycles[%0d]", i), 96'(run_low[i]), 96'(w_of(i)));
          run_high[i] = 0;
        end
        run_high[i]++;
      end
      ss_prev[i] = ss_v[i];
    end
  end

  task automatic wait_idle(input int i);
    int n = 0;
    @(negedge clk);
    while (busy_v[i] !== 1'b0) begin
      if (n == 500) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout[%0d]: got busy after %0d cycles expected idle", i, n);
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic start_frame(input int i, input logic [95:0] tx, input logic [95:0] exp_rx,
                             input int lat, input bit push);
    exp_t e;
    wait_idle(i);
    tx_v[i]    = tx;
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    if (push) begin
      e.id   = i;
      e.data = exp_rx;
      e.acc  = cyc;
      e.lat  = lat;
      sb.push_back(e);
    end
    chk($sformatf("ss_after_accept[%0d]", i), 96'(ss_v[i]), 96'd0);
    chk($sformatf("busy_after_accept[%0d]", i), 96'(busy_v[i]), 96'd1);
    chk($sformatf("first_mosi[%0d]", i), 96'(mosi_v[i]), 96'(tx[w_of(i)-1]));
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while ((pending(i) != 0 || busy_v[i] !== 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL done_timeout[%0d]: got %0d pending expected 0", i, pending(i));
    end
  endtask

  localparam logic [95:0] TX2 = 96'hA5A5_0123_4567_89AB_CDEF_FFFF;

  initial begin
    exp_t e;
    int   n;
    for (int i = 0; i < 4; i++) begin
      rst_v[i]   = 1'b1;
      start_v[i] = 1'b0;
      tx_v[i]    = '0;
    end
    #1;
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_ss[%0d]", i), 96'(ss_v[i]), 96'd1);
      chk($sformatf("reset_mosi[%0d]", i), 96'(mosi_v[i]), 96'd0);
      chk($sformatf("reset_busy[%0d]", i), 96'(busy_v[i]), 96'd0);
      chk($sformatf("reset_done[%0d]", i), 96'(done_v[i]), 96'd0);
      chk($sformatf("reset_rx[%0d]", i), rx_v[i], 96'd0);
    end

    // 96-bit loopback, latency 1
    start_frame(0, TX2, TX2, 98, 1'b1);
    wait_done(0);

    // reset while bit 40 is on the wire
    start_frame(0, 96'h0F0F_1234_5678_9ABC_DEF0_1357, '0, 0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("ss_low_at_bit40", 96'(ss_v[0]), 96'd0);
    abort_v[0] = 1'b1;
    rst_v[0]   = 1'b0;
    #1;
    chk("midreset_ss", 96'(ss_v[0]), 96'd1);
    chk("midreset_busy", 96'(busy_v[0]), 96'd0);
    chk("midreset_done", 96'(done_v[0]), 96'd0);
    chk("midreset_rx", rx_v[0], 96'd0);
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b1;
    repeat (120) @(negedge clk);
    chk("postreset_rx", rx_v[0], 96'd0);
    chk("postreset_busy", 96'(busy_v[0]), 96'd0);

    // 16-bit, zero latency
    start_frame(1, 96'h8001, 96'h8001, 17, 1'b1);
    wait_done(1);

    // latency 3, responder stuck at one
    start_frame(2, 96'h0123_4567_89AB_CDEF_0011_2233, {96{1'b1}}, 100, 1'b1);
    wait_done(2);

    // mid-frame data change and start pulse must not disturb the frame
    start_frame(1, 96'h3C5A, 96'h3C5A, 17, 1'b1);
    repeat (5) @(negedge clk);
    tx_v[1]    = 96'hFFFF;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    wait_done(1);
    repeat (30) @(negedge clk);
    chk("no_extra_frame_busy", 96'(busy_v[1]), 96'd0);

    // back-to-back frames with start held high
    for (int j = 0; j < 5; j++) begin
      e.id   = 3;
      e.data = 96'hC3A5;
      e.acc  = 0;
      e.lat  = -1;
      sb.push_back(e);
    end
    wait_idle(3);
    tx_v[3]    = 96'hC3A5;
    start_v[3] = 1'b1;
    n = 0;
    while (falls[3] < 5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    start_v[3] = 1'b0;
    wait_done(3);
    repeat (30) @(negedge clk);
    chk("frames_accepted[3]", 96'(falls[3]), 96'd5);

    for (int i = 0; i < 4; i++)
      chk($sformatf("pending_done[%0d]", i), 96'(pending(i)), 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got still running at %0t expected finished", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
